// File: rtl/mlsu_req_arbiter.sv
// -----------------------------------------------------------------------------
// mlsu_req_arbiter
//   Shares the single MLSU request port between NrReq PE-side requesters using
//   round-robin arbitration. Outstanding loads and stores are capped separately.
//   The source of every issued request is recorded in a per-class FIFO, and the
//   in-order load/store completions are routed back to their issuer.
//
// Ports
//   clk_i              clock
//   rst_ni             synchronous active-low reset
//   req_valid_i[N]     per-requester request valid
//   req_ready_o[N]     per-requester ready (one-hot or zero)
//   req_i[N]           per-requester request (carries isLoad)
//   mlsu_req_valid_o   request valid towards the MLSU
//   mlsu_req_ready_i   request ready from the MLSU
//   mlsu_req_o         selected request
//   mlsu_resp_load_i   load completion from the MLSU (carries valid)
//   mlsu_resp_store_i  store completion from the MLSU (carries valid)
//   resp_load_o[N]     routed load completions
//   resp_store_o[N]    routed store completions
//   ld_cnt_o/st_cnt_o  outstanding load/store counts
//   idle_o             no lock held and nothing outstanding
//   err_o              sticky: a completion arrived with no recorded source
// -----------------------------------------------------------------------------

package mlsu_req_arbiter_pkg;
  typedef struct packed {
    logic       isLoad;
    logic [6:0] tag;
  } pe_req_t;

  typedef struct packed {
    logic       valid;
    logic [6:0] data;
  } pe_resp_t;
endpackage

module mlsu_req_arbiter #(
  parameter int  NrReq          = 2,
  parameter int  MaxOutstanding = 4,
  parameter type pe_req_t       = mlsu_req_arbiter_pkg::pe_req_t,
  parameter type pe_resp_t      = mlsu_req_arbiter_pkg::pe_resp_t,
  localparam int IdxW           = (NrReq > 1) ? $clog2(NrReq) : 1,
  localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NrReq-1:0]      req_valid_i,
  output logic [NrReq-1:0]      req_ready_o,
  input  pe_req_t [NrReq-1:0]   req_i,
  output logic                  mlsu_req_valid_o,
  input  logic                  mlsu_req_ready_i,
  output pe_req_t               mlsu_req_o,
  input  pe_resp_t              mlsu_resp_load_i,
  input  pe_resp_t              mlsu_resp_store_i,
  output pe_resp_t [NrReq-1:0]  resp_load_o,
  output pe_resp_t [NrReq-1:0]  resp_store_o,
  output logic [CntW-1:0]       ld_cnt_o,
  output logic [CntW-1:0]       st_cnt_o,
  output logic                  idle_o,
  output logic                  err_o
);

  // state     | meaning
  // ST_OPEN   | arbitrate freely among eligible requesters
  // ST_LOCKED | grant held on r_lock_idx until the MLSU accepts it
  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  lock_state_e     r_state;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] r_rr_ptr;
  logic [CntW-1:0] r_ld_cnt;
  logic [CntW-1:0] r_st_cnt;
  logic [PtrW-1:0] r_ld_wr;
  logic [PtrW-1:0] r_ld_rd;
  logic [PtrW-1:0] r_st_wr;
  logic [PtrW-1:0] r_st_rd;
  logic [IdxW-1:0] r_ld_src [MaxOutstanding];
  logic [IdxW-1:0] r_st_src [MaxOutstanding];
  logic            r_err;

  logic            w_ld_full;
  logic            w_st_full;
  logic [NrReq-1:0] w_elig;
  logic            w_found;
  logic [IdxW-1:0] w_pick;
  logic [IdxW:0]   w_idx;
  logic            w_locked;
  logic [IdxW-1:0] w_gnt;
  logic            w_valid;
  logic            w_hs;
  logic            w_gnt_load;
  logic            w_ld_push;
  logic            w_st_push;
  logic            w_ld_pop;
  logic            w_st_pop;
  logic            w_orphan;
  logic [IdxW-1:0] w_ld_head;
  logic [IdxW-1:0] w_st_head;
  logic [IdxW-1:0] w_rr_next;
  logic [CntW-1:0] w_ld_cnt_nxt;
  logic [CntW-1:0] w_st_cnt_nxt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [CntW-1:0] cnt_upd(input logic [CntW-1:0] c,
                                              input logic push, input logic pop);
    logic [CntW-1:0] n;
    n = c;
    if (push && !pop) n = c + CntW'(1);
    else if (pop && !push) n = c - CntW'(1);
    return n;
  endfunction

  // Full flags come from registered counts, so a pop in this cycle cannot
  // unblock a push in the same cycle.
  assign w_ld_full = (r_ld_cnt == CntW'(MaxOutstanding));
  assign w_st_full = (r_st_cnt == CntW'(MaxOutstanding));
  assign w_locked  = (r_state == ST_LOCKED);

  // Rotated fixed priority starting at r_rr_ptr.
  always_comb begin
    w_elig  = '0;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < NrReq; i++) begin
      w_elig[i] = req_valid_i[i] && !(req_i[i].isLoad ? w_ld_full : w_st_full);
    end
    for (int k = 0; k < NrReq; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IdxW+1)'(k);
      if (w_idx >= (IdxW+1)'(NrReq)) w_idx = w_idx - (IdxW+1)'(NrReq);
      if (!w_found && w_elig[w_idx[IdxW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[IdxW-1:0];
      end
    end
  end

  assign w_gnt      = w_locked ? r_lock_idx : w_pick;
  assign w_valid    = rst_ni && (w_locked || w_found);
  assign w_hs       = w_valid && mlsu_req_ready_i;
  assign w_gnt_load = req_i[w_gnt].isLoad;
  assign w_ld_push  = w_hs && w_gnt_load;
  assign w_st_push  = w_hs && !w_gnt_load;
  assign w_rr_next  = (w_gnt == IdxW'(NrReq - 1)) ? '0 : w_gnt + IdxW'(1);

  assign mlsu_req_valid_o = w_valid;
  assign mlsu_req_o       = req_i[w_gnt];

  always_comb begin
    req_ready_o = '0;
    if (w_valid && mlsu_req_ready_i) req_ready_o[w_gnt] = 1'b1;
  end

  // Completions pop only against registered occupancy; a same-cycle push is
  // not yet visible to a response.
  assign w_ld_pop  = mlsu_resp_load_i.valid  && (r_ld_cnt != '0);
  assign w_st_pop  = mlsu_resp_store_i.valid && (r_st_cnt != '0);
  assign w_orphan  = (mlsu_resp_load_i.valid  && (r_ld_cnt == '0)) ||
                     (mlsu_resp_store_i.valid && (r_st_cnt == '0));
  assign w_ld_head = r_ld_src[r_ld_rd];
  assign w_st_head = r_st_src[r_st_rd];

  always_comb begin
    for (int j = 0; j < NrReq; j++) begin
      resp_load_o[j]        = mlsu_resp_load_i;
      resp_load_o[j].valid  = rst_ni && w_ld_pop && (w_ld_head == IdxW'(j));
      resp_store_o[j]       = mlsu_resp_store_i;
      resp_store_o[j].valid = rst_ni && w_st_pop && (w_st_head == IdxW'(j));
    end
  end

  assign w_ld_cnt_nxt = cnt_upd(r_ld_cnt, w_ld_push, w_ld_pop);
  assign w_st_cnt_nxt = cnt_upd(r_st_cnt, w_st_push, w_st_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_OPEN;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
      r_ld_cnt   <= '0;
      r_st_cnt   <= '0;
      r_ld_wr    <= '0;
      r_ld_rd    <= '0;
      r_st_wr    <= '0;
      r_st_rd    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_state  <= ST_OPEN;
        r_rr_ptr <= w_rr_next;
      end else if (w_valid) begin
        r_state    <= ST_LOCKED;
        r_lock_idx <= w_gnt;
      end
      if (w_ld_push) r_ld_wr <= ptr_inc(r_ld_wr);
      if (w_st_push) r_st_wr <= ptr_inc(r_st_wr);
      if (w_ld_pop)  r_ld_rd <= ptr_inc(r_ld_rd);
      if (w_st_pop)  r_st_rd <= ptr_inc(r_st_rd);
      r_ld_cnt <= w_ld_cnt_nxt;
      r_st_cnt <= w_st_cnt_nxt;
      if (w_orphan) r_err <= 1'b1;
    end
  end

  // Source storage needs no reset: occupancy is tracked by the counters.
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_ld_push) r_ld_src[r_ld_wr] <= w_gnt;
    if (rst_ni && w_st_push) r_st_src[r_st_wr] <= w_gnt;
  end

  assign ld_cnt_o = r_ld_cnt;
  assign st_cnt_o = r_st_cnt;
  assign idle_o   = !rst_ni || (!w_locked && (r_ld_cnt == '0) && (r_st_cnt == '0));
  assign err_o    = r_err;

endmodule

// File: tb/tb_mlsu_req_arbiter.sv
module tb_mlsu_req_arbiter;
  import mlsu_req_arbiter_pkg::*;

  localparam int N    = 2;
  localparam int MAXO = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  pe_req_t [N-1:0] req;
  logic            mlsu_valid;
  logic            mlsu_ready;
  pe_req_t         mlsu_req;
  pe_resp_t        resp_ld;
  pe_resp_t        resp_st;
  pe_resp_t [N-1:0] resp_load;
  pe_resp_t [N-1:0] resp_store;
  logic [2:0]      ld_cnt;
  logic [2:0]      st_cnt;
  logic            idle;
  logic            err;

  int checks = 0;
  int errors = 0;

  // Reference model: source queues per class, round-robin pointer, lock.
  int m_rr;
  bit m_locked;
  int m_lidx;
  int ldq[$];
  int stq[$];
  bit m_err;

  mlsu_req_arbiter #(.NrReq(N), .MaxOutstanding(MAXO)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_i             (req),
    .mlsu_req_valid_o  (mlsu_valid),
    .mlsu_req_ready_i  (mlsu_ready),
    .mlsu_req_o        (mlsu_req),
    .mlsu_resp_load_i  (resp_ld),
    .mlsu_resp_store_i (resp_st),
    .resp_load_o       (resp_load),
    .resp_store_o      (resp_store),
    .ld_cnt_o          (ld_cnt),
    .st_cnt_o          (st_cnt),
    .idle_o            (idle),
    .err_o             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_locked = 0;
    m_lidx = 0;
    ldq.delete();
    stq.delete();
    m_err = 0;
  endtask

  task automatic set_req(input int i, input bit v, input bit ld, input logic [6:0] tag);
    req_valid[i]  = v;
    req[i].isLoad = ld;
    req[i].tag    = tag;
  endtask

  task automatic set_resp(input bit lv, input logic [6:0] ld, input bit sv, input logic [6:0] sd);
    resp_ld.valid = lv;
    resp_ld.data  = ld;
    resp_st.valid = sv;
    resp_st.data  = sd;
  endtask

  // One clock: predict from the model, compare mid-cycle, then advance the model.
  task automatic cycle();
    int  g;
    bit  v;
    bit  hs;
    bit  eligible;
    bit  ld_pop;
    bit  st_pop;
    bit  orphan;
    int  ld_head;
    int  st_head;
    logic [N-1:0] exp_rdy;
    g = -1;
    if (m_locked) g = m_lidx;
    else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        eligible = req_valid[i] &&
                   !(req[i].isLoad ? (ldq.size() == MAXO) : (stq.size() == MAXO));
        if (g < 0 && eligible) g = i;
      end
    end
    v = rst_n && (g >= 0);
    hs = v && mlsu_ready;
    exp_rdy = '0;
    if (hs) exp_rdy[g] = 1'b1;
    ld_pop = rst_n && resp_ld.valid && (ldq.size() > 0);
    st_pop = rst_n && resp_st.valid && (stq.size() > 0);
    orphan = (resp_ld.valid && ldq.size() == 0) || (resp_st.valid && stq.size() == 0);
    ld_head = (ldq.size() > 0) ? ldq[0] : -1;
    st_head = (stq.size() > 0) ? stq[0] : -1;

    @(negedge clk);
    chk("req_valid", mlsu_valid, v);
    chk("req_ready", req_ready, exp_rdy);
    if (v) chk("req_payload", mlsu_req, req[g]);
    for (int j = 0; j < N; j++) begin
      chk("ld_resp_valid", resp_load[j].valid,  ld_pop && (ld_head == j));
      chk("ld_resp_data",  resp_load[j].data,   resp_ld.data);
      chk("st_resp_valid", resp_store[j].valid, st_pop && (st_head == j));
      chk("st_resp_data",  resp_store[j].data,  resp_st.data);
    end
    chk("ld_cnt", ld_cnt, ldq.size());
    chk("st_cnt", st_cnt, stq.size());
    chk("idle", idle, !rst_n || (!m_locked && ldq.size() == 0 && stq.size() == 0));
    chk("err", err, m_err);

    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
      if (ld_pop) void'(ldq.pop_front());
      if (st_pop) void'(stq.pop_front());
      if (orphan) m_err = 1;
      if (hs) begin
        if (req[g].isLoad) ldq.push_back(g);
        else stq.push_back(g);
        m_rr = (g + 1) % N;
        m_locked = 0;
      end else if (v) begin
        m_locked = 1;
        m_lidx = g;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req = '0;
    mlsu_ready = 1'b0;
    set_resp(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    set_resp(1, 7'h11, 1, 7'h22);  // responses ignored while in reset
    cycle();
    set_resp(0, 0, 0, 0);
    rst_n = 1'b1;

    // Both requesters stream loads: grants alternate, then loads fill up.
    set_req(0, 1, 1, 7'h10);
    set_req(1, 1, 1, 7'h20);
    mlsu_ready = 1'b1;
    repeat (6) cycle();
    chk("ld_full_cnt", ld_cnt, 4);

    // Drain the four loads.
    set_req(0, 0, 1, 0);
    set_req(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      set_resp(1, 7'(8'h30 + i), 0, 0);
      cycle();
    end
    set_resp(0, 0, 0, 0);

    // Lock: requester 0 held for 3 cycles while requester 1 waits.
    mlsu_ready = 1'b0;
    set_req(0, 1, 0, 7'h31);
    cycle();
    set_req(1, 1, 1, 7'h41);
    cycle();
    cycle();
    mlsu_ready = 1'b1;
    cycle();
    set_req(0, 0, 0, 0);
    cycle();
    set_req(1, 0, 1, 0);

    // Fill loads from requester 0, then a store from requester 1 still goes.
    set_req(0, 1, 1, 7'h12);
    repeat (4) cycle();
    set_req(1, 1, 0, 7'h55);
    cycle();
    set_req(1, 0, 0, 0);
    chk("st_after_full", st_cnt, 2);

    // Full loads: response and new load in the same cycle gives no grant.
    set_resp(1, 7'h66, 0, 0);
    cycle();
    chk("ld_cnt_dip", ld_cnt, 3);
    set_resp(0, 0, 0, 0);
    cycle();
    chk("ld_cnt_refill", ld_cnt, 4);
    set_req(0, 0, 1, 0);

    // Drain everything: 4 loads and 2 stores.
    for (int i = 0; i < 4; i++) begin
      set_resp(1, 7'(8'h70 + i), i < 2, 7'(8'h78 + i));
      cycle();
    end
    set_resp(0, 0, 0, 0);
    cycle();
    chk("idle_drained", idle, 1);

    // Ordered routing: load from 1, load from 0, store from 0.
    set_req(1, 1, 1, 7'h01);
    cycle();
    set_req(1, 0, 1, 0);
    set_req(0, 1, 1, 7'h02);
    cycle();
    set_req(0, 1, 0, 7'h03);
    cycle();
    set_req(0, 0, 0, 0);
    set_resp(1, 7'h5a, 0, 0);
    cycle();
    set_resp(1, 7'h5b, 1, 7'h5c);
    cycle();
    set_resp(0, 0, 0, 0);
    cycle();
    chk("idle_after_route", idle, 1);

    // Orphan store response sets a sticky error.
    set_resp(0, 0, 1, 7'h7e);
    cycle();
    set_resp(0, 0, 0, 0);
    repeat (2) cycle();
    chk("err_sticky", err, 1);

    // Reset while locked.
    mlsu_ready = 1'b0;
    set_req(0, 1, 1, 7'h44);
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    set_req(0, 0, 1, 0);
    cycle();
    chk("err_cleared", err, 0);
    chk("unlocked_valid", mlsu_valid, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < N; i++) begin
        if (!(m_locked && i == m_lidx))
          set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 1), 7'($urandom));
      end
      mlsu_ready = ($urandom_range(0, 3) != 0);
      set_resp($urandom_range(0, 2) == 0, 7'($urandom),
               $urandom_range(0, 2) == 0, 7'($urandom));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
